timer_irq_unit: RTL and testbench



---
 rtl/periph_pkg.sv | 33 +++
 rtl/timer_irq_unit.sv | 85 ++++++++
 tb/tb_timer_irq_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/periph_pkg.sv
// Shared definitions for memory-mapped peripherals on the MIPS data bus:
// the window base, register offsets and TCON bit positions.
package periph_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  localparam logic [3:0] TH_OFF      = 4'h0;
  localparam logic [3:0] TL_OFF      = 4'h4;
  localparam logic [3:0] TCON_OFF    = 4'h8;
  localparam logic [3:0] SYSTICK_OFF = 4'hC;

  localparam int EN_BIT = 0;
  localparam int IE_BIT = 1;
  localparam int ST_BIT = 2;

  typedef enum logic [1:0] {
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_SYSTICK
  } reg_sel_e;

  // Byte-lane bits of the offset are don't-care; only the word index selects.
  function automatic reg_sel_e decode_sel(input logic [3:0] off);
    case ({off[3:2], 2'b00})
      TH_OFF:   return REG_TH;
      TL_OFF:   return REG_TL;
      TCON_OFF: return REG_TCON;
      default:  return REG_SYSTICK;
    endcase
  endfunction

endpackage

// File: rtl/timer_irq_unit.sv
// Interval timer with reload, sticky overflow status and a free-running
// SYSTICK, mapped as a 4-word window on the CPU data bus.
module timer_irq_unit
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE  = PERIPH_BASE,
  parameter int          WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        kernel,
  output logic        irq
);

  logic [WIDTH-1:0] th;
  logic [WIDTH-1:0] tl;
  logic [WIDTH-1:0] systick;
  logic [2:0]       tcon;

  reg_sel_e sel;
  logic     wr_en;
  logic     overflow;
  logic     set_st;
  logic     unused_addr;

  assign hit         = (addr[31:4] == BASE[31:4]);
  assign sel         = decode_sel(addr[3:0]);
  assign wr_en       = mem_wr & hit;
  assign unused_addr = ^addr[1:0];

  // EN and IE are the pre-write values, so an edge that also writes TCON
  // still counts and still latches its overflow.
  assign overflow = tcon[EN_BIT] & (&tl);
  assign set_st   = overflow & tcon[IE_BIT];

  assign irq = tcon[ST_BIT] & tcon[IE_BIT] & ~kernel;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other one, e.g. the reload below
  // picks up the old TH even when TH is written on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      systick <= '0;
      tcon    <= '0;
    end else begin
      systick <= systick + WIDTH'(1);

      if (wr_en && sel == REG_TH) th <= wdata[WIDTH-1:0];

      if (wr_en && sel == REG_TL)  tl <= wdata[WIDTH-1:0];
      else if (tcon[EN_BIT])       tl <= overflow ? th : tl + WIDTH'(1);

      if (wr_en && sel == REG_TCON) begin
        tcon[EN_BIT] <= wdata[EN_BIT];
        tcon[IE_BIT] <= wdata[IE_BIT];
        tcon[ST_BIT] <= wdata[ST_BIT] | set_st;
      end else if (set_st) begin
        tcon[ST_BIT] <= 1'b1;
      end
    end
  end

  // NOTE: rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    if (mem_rd && hit) begin
      unique case (sel)
        REG_TH:      rdata = 32'(th);
        REG_TL:      rdata = 32'(tl);
        REG_TCON:    rdata = {29'd0, tcon};
        REG_SYSTICK: rdata = 32'(systick);
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Directed bench for timer_irq_unit: stimulus queues expected bus responses,
// a monitor compares them against rdata/irq/hit mid-cycle.
module tb_timer_irq_unit;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        kernel;
  logic        irq;

  logic        probe;
  logic [31:0] sys_m;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        irq;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];

  timer_irq_unit dut (
    .clk    (clk),
    .reset  (reset),
    .mem_rd (mem_rd),
    .mem_wr (mem_wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .kernel (kernel),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running counter: edges seen since reset released.
  always @(posedge clk) begin
    if (reset) sys_m <= 32'd0;
    else       sys_m <= sys_m + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the commit edge.
  always @(negedge clk) begin
    if (!reset && (mem_rd || probe)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got rdata %h with no expected entry", rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".rdata"}, rdata, e.rdata);
        check({e.name, ".irq"},   {31'd0, irq}, {31'd0, e.irq});
        check({e.name, ".hit"},   {31'd0, hit}, {31'd0, e.hit});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] a, input logic rd, input logic [31:0] exp_rdata,
                      input logic exp_irq, input logic exp_hit, input string name);
    exp_t e;
    mem_wr = 1'b0;
    mem_rd = rd;
    addr   = a;
    probe  = 1'b1;
    e.name = name; e.rdata = exp_rdata; e.irq = exp_irq; e.hit = exp_hit;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp_rdata,
                    input logic exp_irq, input string name);
    look(BASE + {28'd0, off}, 1'b1, exp_rdata, exp_irq, 1'b1, name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_wr = 1'b1;
    mem_rd = 1'b0;
    probe  = 1'b0;
    addr   = a;
    wdata  = d;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; probe = 1'b0;
    addr = '0; wdata = '0; kernel = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(4'hC, 32'd0, 1'b0, "rst_systick");
    rd(4'h0, 32'd0, 1'b0, "rst_th");
    rd(4'h4, 32'd0, 1'b0, "rst_tl");
    rd(4'h8, 32'd0, 1'b0, "rst_tcon");

    // Count up to all-ones, reload from TH
    wr(BASE + 32'h0, 32'hFFFF_FFFC);
    wr(BASE + 32'h4, 32'hFFFF_FFFC);
    wr(BASE + 32'h8, 32'd3);
    rd(4'h4, 32'hFFFF_FFFC, 1'b0, "tl_start");
    rd(4'h4, 32'hFFFF_FFFD, 1'b0, "tl_fd");
    rd(4'h4, 32'hFFFF_FFFE, 1'b0, "tl_fe");
    rd(4'h4, 32'hFFFF_FFFF, 1'b0, "tl_ff");
    rd(4'h4, 32'hFFFF_FFFC, 1'b1, "tl_reload");

    // Software clear, then the next overflow sets ST again
    wr(BASE + 32'h8, 32'd3);
    rd(4'h8, 32'd3, 1'b0, "st_cleared");
    rd(4'h4, 32'hFFFF_FFFF, 1'b0, "tl_before_ovf2");
    rd(4'h8, 32'd7, 1'b1, "st_after_ovf2");

    // TCON write with ST=0 on the overflow edge: the set wins
    wr(BASE + 32'h8, 32'd3);
    rd(4'h8, 32'd3, 1'b0, "st_cleared2");
    wr(BASE + 32'h8, 32'd3);
    rd(4'h8, 32'd7, 1'b1, "tcon_wr_on_ovf");

    // TL write on the overflow edge: the write wins over the reload
    rd(4'h4, 32'hFFFF_FFFD, 1'b1, "tl_fd_b");
    rd(4'h4, 32'hFFFF_FFFE, 1'b1, "tl_fe_b");
    wr(BASE + 32'h4, 32'd5);
    rd(4'h4, 32'd5, 1'b1, "tl_wr_on_ovf");

    // TH write on the overflow edge: reload uses the old TH
    wr(BASE + 32'h4, 32'hFFFF_FFFE);
    rd(4'h4, 32'hFFFF_FFFE, 1'b1, "tl_fe_c");
    wr(BASE + 32'h0, 32'h10);
    rd(4'h4, 32'hFFFF_FFFC, 1'b1, "th_wr_on_ovf_old");
    rd(4'h0, 32'h10, 1'b1, "th_new");

    // Kernel mode masks irq but ST is kept
    wr(BASE + 32'h8, 32'd3);
    kernel = 1'b1;
    rd(4'h8, 32'd3, 1'b0, "kernel_pre");
    rd(4'h8, 32'd7, 1'b0, "kernel_mask");
    kernel = 1'b0;
    rd(4'h8, 32'd7, 1'b1, "kernel_drop");

    // SYSTICK is read-only; out-of-window accesses and mem_rd=0
    look(BASE + 32'hC, 1'b1, sys_m, 1'b1, 1'b1, "systick_a");
    wr(BASE + 32'hC, 32'd0);
    rd(4'hC, sys_m, 1'b1, "systick_wr_ignored");
    wr(BASE + 32'h10, 32'hDEAD);
    rd(4'h0, 32'h10, 1'b1, "th_oow_wr_ignored");
    look(BASE + 32'h10, 1'b1, 32'd0, 1'b1, 1'b0, "out_of_window");
    look(BASE + 32'h4, 1'b0, 32'd0, 1'b1, 1'b1, "rd_strobe_low");
    look(BASE + 32'h8, 1'b0, 32'd0, 1'b1, 1'b1, "rd_strobe_low_tcon");

    // Reset mid-count overrides a simultaneous write
    reset = 1'b1; mem_rd = 1'b0; probe = 1'b0;
    mem_wr = 1'b1; addr = BASE; wdata = 32'h55;
    tick();
    reset = 1'b0;
    rd(4'h0, 32'd0, 1'b0, "mid_rst_th");
    rd(4'h4, 32'd0, 1'b0, "mid_rst_tl");
    rd(4'h8, 32'd0, 1'b0, "mid_rst_tcon");
    rd(4'hC, 32'd3, 1'b0, "mid_rst_systick");

    mem_rd = 1'b0; probe = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
